// File: rtl/div_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_sched_pkg
//  Description : Shared types and default constants for the divided-clock
//                scheduler: channel state encoding and default geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package div_sched_pkg;

    // Default geometry
    localparam int unsigned c_n_ch_default  = 4;   // number of channels
    localparam int unsigned c_div_w_default = 8;   // divisor width in bits
    localparam int unsigned c_ch_idx_w      = 4;   // width of cfg_ch

    // Per-channel state
    //   OFF  : idle, outputs held low
    //   RUN  : counting with cur_div
    //   PEND : counting with cur_div, pend_div applied at next terminal count
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } chan_state_e;

endpackage : div_sched_pkg
`default_nettype wire

// File: rtl/div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : div_chan
//  Description : One divided-clock channel. Counts system clocks with the
//                current divisor, emits a one-cycle tick and toggles a square
//                wave at each terminal count. A new divisor is staged in
//                pend_div and only takes over at a terminal count, so the
//                square wave never shows a short or long half-period.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   synchronous active-high reset
//    i_load     in   accepted configuration request addressed to this channel
//    i_div      in   requested divisor (0 = stop)
//    o_tick     out  registered one-cycle enable pulse
//    o_clk      out  registered divided square wave, period 2*div
//    o_active   out  channel state is not OFF (decoded from state flop)
//    o_pend     out  channel is in PEND (request must be held off)
// ============================================================================
module div_chan
    import div_sched_pkg::*;
#(
    parameter int DIV_W = c_div_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_clk,
    output logic             o_active,
    output logic             o_pend
);

    chan_state_e      r_state_q,    w_state_d;
    logic [DIV_W-1:0] r_cnt_q,      w_cnt_d;
    logic [DIV_W-1:0] r_cur_div_q,  w_cur_div_d;
    logic [DIV_W-1:0] r_pend_div_q, w_pend_div_d;
    logic             r_tick_q,     w_tick_d;
    logic             r_clk_q,      w_clk_d;

    logic [DIV_W-1:0] w_last;
    logic             w_term;

    // Terminal count; cur_div is never 0 outside OFF, where w_term is unused.
    assign w_last = r_cur_div_q - DIV_W'(1);
    assign w_term = (r_cnt_q == w_last);

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_cur_div_d  = r_cur_div_q;
        w_pend_div_d = r_pend_div_q;
        w_tick_d     = 1'b0;
        w_clk_d      = r_clk_q;

        case (r_state_q)
            OFF: begin
                w_cnt_d = '0;
                w_clk_d = 1'b0;
                if (i_load && (i_div != '0)) begin
                    w_cur_div_d = i_div;
                    w_state_d   = RUN;
                end
            end

            RUN: begin
                if (w_term) begin
                    w_cnt_d  = '0;
                    w_tick_d = 1'b1;
                    w_clk_d  = ~r_clk_q;
                end else begin
                    w_cnt_d = r_cnt_q + DIV_W'(1);
                end
                // A request coinciding with a terminal count still goes to
                // PEND: the old divisor runs one more full period.
                if (i_load) begin
                    w_pend_div_d = i_div;
                    w_state_d    = PEND;
                end
            end

            PEND: begin
                if (w_term) begin
                    w_tick_d    = 1'b1;
                    w_cnt_d     = '0;
                    w_cur_div_d = r_pend_div_q;
                    if (r_pend_div_q == '0) begin
                        // Stop: force the wave low so a low-to-high toggle
                        // here cannot leave a one-cycle runt pulse.
                        w_state_d = OFF;
                        w_clk_d   = 1'b0;
                    end else begin
                        w_state_d = RUN;
                        w_clk_d   = ~r_clk_q;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                w_state_d = OFF;
                w_cnt_d   = '0;
                w_clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= OFF;
            r_cnt_q      <= '0;
            r_cur_div_q  <= '0;
            r_pend_div_q <= '0;
            r_tick_q     <= 1'b0;
            r_clk_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_cur_div_q  <= w_cur_div_d;
            r_pend_div_q <= w_pend_div_d;
            r_tick_q     <= w_tick_d;
            r_clk_q      <= w_clk_d;
        end
    end

    assign o_tick   = r_tick_q;
    assign o_clk    = r_clk_q;
    assign o_active = (r_state_q != OFF);
    assign o_pend   = (r_state_q == PEND);

endmodule : div_chan
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : div_sched
//  Description : Array of N_CH independent divided-clock channels sharing one
//                configuration port. Decodes requests to a channel, holds off
//                a channel that already has a change pending, and flags
//                requests to nonexistent channels.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   synchronous active-high reset
//    cfg_valid  in   configuration request valid
//    cfg_ready  out  request can be accepted this cycle
//    cfg_ch     in   [4]      target channel index
//    cfg_div    in   [DIV_W]  new divisor, 0 disables the channel
//    cfg_err    out  one-cycle pulse: accepted request named a bad channel
//    tick_out   out  [N_CH]   per-channel one-cycle enable pulse
//    clk_out    out  [N_CH]   per-channel divided square wave
//    active     out  [N_CH]   per-channel "not OFF"
// ============================================================================
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N_CH  = c_n_ch_default,
    parameter int DIV_W = c_div_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  tick_out,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  active
);

    localparam logic [4:0] c_n_ch_lim = 5'(N_CH);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_load;
    logic [15:0]     w_pend_pad;
    logic            w_ch_valid;
    logic            w_accept;
    logic            r_cfg_err_q, w_cfg_err_d;

    assign w_ch_valid = ({1'b0, cfg_ch} < c_n_ch_lim);

    // Pad the pending vector to the full index range so any cfg_ch value
    // indexes a real bit; nonexistent channels read as "not pending".
    always_comb begin
        w_pend_pad           = '0;
        w_pend_pad[N_CH-1:0] = w_pend;
    end

    assign cfg_ready = ~(w_ch_valid & w_pend_pad[cfg_ch]);
    assign w_accept  = cfg_valid & cfg_ready;

    assign w_cfg_err_d = w_accept & ~w_ch_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err_q <= 1'b0;
        end else begin
            r_cfg_err_q <= w_cfg_err_d;
        end
    end

    assign cfg_err = r_cfg_err_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign w_load[gi] = w_accept & w_ch_valid & (cfg_ch == 4'(gi));

        div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load[gi]),
            .i_div    (cfg_div),
            .o_tick   (tick_out[gi]),
            .o_clk    (clk_out[gi]),
            .o_active (active[gi]),
            .o_pend   (w_pend[gi])
        );
    end

endmodule : div_sched
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_sched
//  Description : Directed self-checking bench for div_sched (N_CH=4, DIV_W=8).
//                Position k means "just after the k-th edge following the
//                accept edge"; expected values are hand-derived from k.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_ch = 4'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_err;
    logic [3:0] tick_out;
    logic [3:0] clk_out;
    logic [3:0] active;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_sched #(
        .N_CH  (4),
        .DIV_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick_out  (tick_out),
        .clk_out   (clk_out),
        .active    (active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Present a request and let one edge accept it; returns at position k=0.
    task automatic accept(input logic [3:0] ch, input logic [7:0] div);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tick_out, clk_out, active} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=000", {tick_out, clk_out, active});
        end
        checks++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg got err=%b rdy=%b exp err=0 rdy=1", cfg_err, cfg_ready);
        end
    endtask

    task automatic test_div5();
        logic et, ec;
        do_reset();
        accept(4'd0, 8'd5);
        checks++;
        if (active !== 4'b0001 || tick_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL div5_start got act=%b tick=%b exp act=0001 tick=0", active, tick_out[0]);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            et = (k % 5 == 0);
            ec = ((k / 5) % 2 == 1);
            checks++;
            if (tick_out[0] !== et || clk_out[0] !== ec) begin
                errors++;
                $display("FAIL div5 k=%0d got tick=%b clk=%b exp tick=%b clk=%b",
                         k, tick_out[0], clk_out[0], et, ec);
            end
        end
    endtask

    task automatic test_retarget();
        logic et, ec, er;
        do_reset();
        accept(4'd1, 8'd3);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 5) cfg_valid = 1'b0;
            et = (k == 3) || (k == 6) || (k == 12) || (k == 18);
            ec = (k >= 3 && k <= 5) || (k >= 12 && k <= 17);
            er = (k != 5);
            checks++;
            if (tick_out[1] !== et || clk_out[1] !== ec || cfg_ready !== er) begin
                errors++;
                $display("FAIL retarget k=%0d got tick=%b clk=%b rdy=%b exp tick=%b clk=%b rdy=%b",
                         k, tick_out[1], clk_out[1], cfg_ready, et, ec, er);
            end
            if (k == 4) begin
                cfg_valid = 1'b1;
                cfg_ch    = 4'd1;
                cfg_div   = 8'd6;
            end
        end
    endtask

    task automatic test_stop();
        logic et, ec, ea;
        do_reset();
        accept(4'd2, 8'd4);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 10) cfg_valid = 1'b0;
            et = (k == 4) || (k == 8) || (k == 12);
            ec = (k >= 4 && k <= 7);
            ea = (k < 12);
            checks++;
            if (tick_out[2] !== et || clk_out[2] !== ec || active[2] !== ea) begin
                errors++;
                $display("FAIL stop k=%0d got tick=%b clk=%b act=%b exp tick=%b clk=%b act=%b",
                         k, tick_out[2], clk_out[2], active[2], et, ec, ea);
            end
            if (k == 9) begin
                cfg_valid = 1'b1;
                cfg_ch    = 4'd2;
                cfg_div   = 8'd0;
            end
        end
    endtask

    task automatic test_bad_ch();
        logic et, ee;
        do_reset();
        accept(4'd0, 8'd2);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) cfg_valid = 1'b0;
            et = (k % 2 == 0);
            ee = (k == 4);
            checks++;
            if (tick_out !== {3'b000, et} || active !== 4'b0001 || cfg_err !== ee) begin
                errors++;
                $display("FAIL bad_ch k=%0d got tick=%b act=%b err=%b exp tick=000%b act=0001 err=%b",
                         k, tick_out, active, cfg_err, et, ee);
            end
            if (k == 3) begin
                cfg_valid = 1'b1;
                cfg_ch    = 4'd7;
                cfg_div   = 8'd9;
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bad_ch_ready got=%b exp=1", cfg_ready);
                end
            end
        end
    endtask

    task automatic test_div1_reset();
        logic ec;
        do_reset();
        accept(4'd3, 8'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            ec = (k % 2 == 1);
            checks++;
            if (tick_out[3] !== 1'b1 || clk_out[3] !== ec) begin
                errors++;
                $display("FAIL div1 k=%0d got tick=%b clk=%b exp tick=1 clk=%b",
                         k, tick_out[3], clk_out[3], ec);
            end
        end
        // Reset together with a request: reset wins, request is discarded.
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 4'd0;
        cfg_div   = 8'd3;
        step();
        checks++;
        if ({tick_out, clk_out, active, cfg_err} !== 13'h0000) begin
            errors++;
            $display("FAIL div1_reset got=%h exp=0000", {tick_out, clk_out, active, cfg_err});
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        step();
        checks++;
        if (active !== 4'b0000 || tick_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_override got act=%b tick=%b exp act=0000 tick=0000", active, tick_out);
        end
    endtask

    task automatic test_coincident();
        logic et, ec, er;
        do_reset();
        accept(4'd0, 8'd3);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 3) cfg_valid = 1'b0;
            et = (k == 3) || (k == 6) || (k == 8) || (k == 10);
            ec = (k >= 3 && k <= 5) || (k >= 8 && k <= 9);
            er = !(k >= 3 && k <= 5);
            checks++;
            if (tick_out[0] !== et || clk_out[0] !== ec || cfg_ready !== er) begin
                errors++;
                $display("FAIL coincident k=%0d got tick=%b clk=%b rdy=%b exp tick=%b clk=%b rdy=%b",
                         k, tick_out[0], clk_out[0], cfg_ready, et, ec, er);
            end
            if (k == 2) begin
                cfg_valid = 1'b1;
                cfg_ch    = 4'd0;
                cfg_div   = 8'd2;
            end
        end
    endtask

    initial begin
        test_reset();
        test_div5();
        test_retarget();
        test_stop();
        test_bad_ch();
        test_div1_reset();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_sched
`default_nettype wire

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: divisor width in bits.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration request valid.
REQ-006 SHALL have port cfg_ready  output  1  configuration request can be accepted this cycle.
REQ-007 SHALL have port cfg_ch  input  4  target channel index.
REQ-008 SHALL have port cfg_div  input  DIV_W  new divisor; 0 means disable the channel.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse: the accepted request named a nonexistent channel.
REQ-010 SHALL have port tick_out  output  N_CH  per-channel one-cycle enable pulse, once every div cycles.
REQ-011 SHALL have port clk_out  output  N_CH  per-channel divided square wave, period 2*div.
REQ-012 SHALL have port active  output  N_CH  channel state is not OFF.

Function
REQ-013 SHALL accept a request on any rising edge where cfg_valid and cfg_ready are both 1.
REQ-014 SHALL keep a per-channel state machine with states OFF, RUN and PEND.
REQ-015 SHALL register tick_out, clk_out and active; none of them SHALL be driven combinationally from inputs.
REQ-016 Channel in OFF: SHALL hold cnt = 0, tick_out = 0 and clk_out = 0.
REQ-017 OFF, accepted with cfg_div != 0: SHALL load cur_div, clear cnt and enter RUN on the accept edge; the first tick_out SHALL occur cur_div cycles after the accept edge.
REQ-018 OFF, accepted with cfg_div = 0: SHALL remain in OFF (no-op).
REQ-019 RUN: cnt SHALL increment each cycle; when cnt = cur_div-1, cnt SHALL wrap to 0, tick_out SHALL be 1 for the next cycle, and clk_out SHALL toggle on the same edge.
REQ-020 Divisor 1: tick_out SHALL stay continuously 1 and clk_out SHALL toggle every cycle.
REQ-021 RUN, accepted: SHALL store cfg_div in pend_div and enter PEND; cur_div SHALL be unchanged.
REQ-022 PEND: SHALL count with cur_div; at terminal count, the tick and toggle SHALL occur normally, then cur_div SHALL load pend_div and cnt restart at 0; the next state SHALL be RUN, or OFF if pend_div = 0.
REQ-023 When a PEND channel goes to OFF, clk_out SHALL be forced to 0 on that edge (this is the glitch-free stop).
REQ-024 A request accepted in the same cycle as a RUN terminal count SHALL go to PEND; the old divisor SHALL govern one further full period.
REQ-025 cfg_ready SHALL be 0 exactly when cfg_ch < N_CH and that channel is in PEND; otherwise it SHALL be 1.
REQ-026 An accepted cfg_ch >= N_CH SHALL be dropped, cfg_err SHALL pulse high for one cycle, and no channel SHALL change.
REQ-027 Channels SHALL be fully independent; a request SHALL affect only the addressed channel.

Reset
REQ-028 While rst = 1 at an edge: all channels SHALL go to OFF, with cnt, cur_div, pend_div, tick_out, clk_out, active and cfg_err all 0.
REQ-029 Reset SHALL override any request in the same cycle; a pending change SHALL be discarded.
REQ-030 Reset applied mid-period SHALL take effect on the next edge, with no partial tick.

Structure
REQ-031 Package div_sched_pkg SHALL hold the channel state enum (OFF/RUN/PEND) and the default N_CH and DIV_W constants.
REQ-032 The per-channel counter and state machine SHALL be the sub-module div_chan, instantiated N_CH times.
REQ-033 div_sched SHALL contain only request decode, cfg_ready/cfg_err generation and the instance array.

Verification
REQ-034 Scenario: reset, then write ch0 div=5 -> first tick 5 cycles after accept; tick every 5 cycles; clk_out0 period 10.
REQ-035 Scenario: ch1 running div=3, write div=6 mid-period -> cfg_ready low while in PEND; change applied exactly at the next terminal count; no short or long clk_out half-period.
REQ-036 Scenario: ch2 div=4 running, write div=0 -> ch2 finishes its current period, then active2 = 0 and clk_out2 = 0 with no runt pulse.
REQ-037 Scenario: write cfg_ch=7 with N_CH=4 -> cfg_err pulses 1 cycle; all channels unchanged.
REQ-038 Scenario: ch3 div=1 -> tick_out3 held 1 and clk_out3 toggles every cycle; assert rst mid-stream -> all outputs 0 on the next edge.
REQ-039 Scenario: a write coincident with a terminal count -> the old divisor governs one more full period before the new one applies.
